sram_rr_arbiter: RTL and testbench

Shares one single-port SRAM/boot-ROM macro (1-cycle registered read latency, byte-enable writes) between NUM_REQ requesters such as core instruction fetch, core data port and the JTAG debug loader. It uses round-robin arbitration with a req/gnt/rvalid handshake and routes read data back to the winning requester. An optional write-protect input turns the memory into a ROM for non-debug masters after boot.

---
 rtl/sram_rr_arbiter_pkg.sv | 24 ++
 rtl/sram_rr_arbiter_if.sv | 29 ++
 rtl/sram_rr_arbiter_prio_sel.sv | 29 ++
 rtl/sram_rr_arbiter.sv | 91 +++++++++
 tb/tb_sram_rr_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin SRAM arbiter.
package sram_arb_pkg;

   localparam int unsigned MAX_REQ = 8;
   localparam int unsigned ID_W    = $clog2(MAX_REQ);

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
      logic            err;
   } resp_t;

   // Pointer after a grant to k; an out-of-range k leaves the pointer where it was.
   function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] ptr,
                                                input logic [ID_W-1:0] k,
                                                input int unsigned     n);
      int unsigned nxt;
      if (32'(k) >= n) return ptr;
      nxt = 32'(k) + 32'd1;
      if (nxt >= n) return '0;
      return nxt[ID_W-1:0];
   endfunction

endpackage

// File: rtl/sram_rr_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: packed per-requester request fields and shared response.
interface sram_rr_arbiter_if #(
   parameter int unsigned NUM_REQ    = 3,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10
);
   localparam int unsigned BE_WIDTH = (DATA_WIDTH + 7) / 8;

   logic [NUM_REQ-1:0]            req_i;
   logic [NUM_REQ-1:0]            we_i;
   logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i;
   logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i;
   logic [NUM_REQ*BE_WIDTH-1:0]   be_i;
   logic [NUM_REQ-1:0]            gnt_o;
   logic [NUM_REQ-1:0]            rvalid_o;
   logic [DATA_WIDTH-1:0]         rdata_o;
   logic                          err_o;

   modport master (
      output req_i, we_i, addr_i, wdata_i, be_i,
      input  gnt_o, rvalid_o, rdata_o, err_o
   );

   modport slave (
      input  req_i, we_i, addr_i, wdata_i, be_i,
      output gnt_o, rvalid_o, rdata_o, err_o
   );

endinterface

// File: rtl/sram_rr_arbiter_prio_sel.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NUM_REQ.
module rr_prio_sel
   import sram_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]    idx_o,
   output logic               valid_o
);

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!valid_o && req_i[k] && (k == (32'(ptr_i) + off) % NUM_REQ)) begin
               valid_o  = 1'b1;
               gnt_o[k] = 1'b1;
               idx_o    = ID_W'(k);
            end
         end
      end
   end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_REQ requesters,
// with write protection for non-exempt requesters and in-order one-cycle responses.
module sram_rr_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned        NUM_REQ    = 3,
   parameter int unsigned        DATA_WIDTH = 32,
   parameter int unsigned        NUM_WORDS  = 1024,
   parameter logic [NUM_REQ-1:0] WP_EXEMPT  = 3'b100,
   localparam int unsigned       ADDR_WIDTH = $clog2(NUM_WORDS),
   localparam int unsigned       BE_WIDTH   = (DATA_WIDTH + 7) / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   sram_rr_arbiter_if.slave      bus,
   input  logic                  wp_i,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   output logic [BE_WIDTH-1:0]   mem_be_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   logic [ID_W-1:0]    ptr_q;
   resp_t              resp_q;
   logic [NUM_REQ-1:0] req_live;
   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    win;
   logic               any_gnt;
   logic               win_we;
   logic               win_exempt;
   logic               blocked;

   assign req_live = rst_i ? '0 : bus.req_i;

   rr_prio_sel #(
      .NUM_REQ (NUM_REQ)
   ) u_prio_sel (
      .req_i   (req_live),
      .ptr_i   (ptr_q),
      .gnt_o   (gnt),
      .idx_o   (win),
      .valid_o (any_gnt)
   );

   always_comb begin
      win_we      = 1'b0;
      win_exempt  = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (gnt[k]) begin
            win_we      = bus.we_i[k];
            win_exempt  = WP_EXEMPT[k];
            mem_addr_o  = bus.addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata_o = bus.wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            mem_be_o    = bus.be_i[k*BE_WIDTH +: BE_WIDTH];
         end
      end
   end

   // A protected write is still granted and answered, but never reaches the macro.
   assign blocked   = any_gnt & win_we & wp_i & ~win_exempt;
   assign mem_req_o = any_gnt & ~blocked;
   assign mem_we_o  = win_we;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q  <= '0;
         resp_q <= '0;
      end else begin
         if (any_gnt) ptr_q <= rr_next(ptr_q, win, NUM_REQ);
         resp_q <= '{valid: any_gnt, id: win, err: blocked};
      end
   end

   // Masking with rst_i drops a reply already registered when reset arrives.
   always_comb begin
      bus.rvalid_o = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         bus.rvalid_o[k] = resp_q.valid & ~rst_i & (resp_q.id == ID_W'(k));
      end
   end

   assign bus.gnt_o   = gnt;
   assign bus.err_o   = resp_q.valid & resp_q.err & ~rst_i;
   assign bus.rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: vector table, hand-written corner sequences and random
// traffic compared against a behavioural model, with a simple SRAM behind the DUT.
module tb_sram_rr_arbiter;

   localparam int N  = 3;
   localparam int DW = 32;
   localparam int NW = 1024;
   localparam int AW = 10;
   localparam int BW = 4;
   localparam logic [N-1:0] EXEMPT = 3'b100;

   logic clk = 1'b0;
   logic rst;
   logic wp;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [BW-1:0] mem_be;

   logic [N-1:0]  r_req, r_we;
   logic [AW-1:0] r_addr [N];
   logic [DW-1:0] r_wd   [N];
   logic [BW-1:0] r_be   [N];

   int n_chk  = 0;
   int n_fail = 0;

   sram_rr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

   sram_rr_arbiter #(
      .NUM_REQ    (N),
      .DATA_WIDTH (DW),
      .NUM_WORDS  (NW),
      .WP_EXEMPT  (EXEMPT)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .bus         (bus_if),
      .wp_i        (wp),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_be_o    (mem_be),
      .mem_rdata_i (mem_rdata)
   );

   always #5 clk = ~clk;

   assign bus_if.req_i = r_req;
   assign bus_if.we_i  = r_we;
   always_comb begin
      bus_if.addr_i  = '0;
      bus_if.wdata_i = '0;
      bus_if.be_i    = '0;
      for (int k = 0; k < N; k++) begin
         bus_if.addr_i[k*AW +: AW]  = r_addr[k];
         bus_if.wdata_i[k*DW +: DW] = r_wd[k];
         bus_if.be_i[k*BW +: BW]    = r_be[k];
      end
   end

   function automatic logic [DW-1:0] pre(input int unsigned a);
      return 32'hA5C3_0000 ^ (32'(a) * 32'h0001_0203);
   endfunction

   // Single-port SRAM with one-cycle registered read; non-read cycles return 0.
   logic [DW-1:0] sram [NW];
   bit loaded;
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < NW; i++) sram[i] <= pre(i);
         loaded    <= 1'b1;
         mem_rdata <= '0;
      end else if (mem_req && mem_we) begin
         for (int b = 0; b < BW; b++)
            if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         mem_rdata <= '0;
      end else if (mem_req) begin
         mem_rdata <= sram[mem_addr];
      end else begin
         mem_rdata <= '0;
      end
   end

   // Reference model state
   logic [DW-1:0] ref_mem [NW];
   int            m_ptr;
   bit            mr_valid, mr_err, mr_rd;
   int            mr_id;
   logic [DW-1:0] mr_data;
   int            last_win;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Check the current cycle against the model at the falling edge, then advance the model.
   task automatic eval();
      int w;
      bit blk;
      logic [N-1:0] eg, erv;
      @(negedge clk);
      w = -1;
      if (!rst)
         for (int off = 0; off < N; off++)
            if (w < 0 && r_req[(m_ptr + off) % N]) w = (m_ptr + off) % N;
      eg = '0;
      if (w >= 0) eg[w] = 1'b1;
      blk = (w >= 0) && r_we[w] && wp && !EXEMPT[w];
      chk("m_gnt", 64'(bus_if.gnt_o), 64'(eg));
      chk("m_mem_req", 64'(mem_req), 64'(w >= 0 && !blk));
      if (w >= 0 && !blk) begin
         chk("m_mem_addr", 64'(mem_addr), 64'(r_addr[w]));
         chk("m_mem_we", 64'(mem_we), 64'(r_we[w]));
         if (r_we[w]) begin
            chk("m_mem_wdata", 64'(mem_wdata), 64'(r_wd[w]));
            chk("m_mem_be", 64'(mem_be), 64'(r_be[w]));
         end
      end
      erv = '0;
      if (!rst && mr_valid) erv[mr_id] = 1'b1;
      chk("m_rvalid", 64'(bus_if.rvalid_o), 64'(erv));
      chk("m_err", 64'(bus_if.err_o), 64'(!rst && mr_valid && mr_err));
      if (!rst && mr_valid && mr_rd) chk("m_rdata", 64'(bus_if.rdata_o), 64'(mr_data));
      if (rst) begin
         m_ptr    = 0;
         mr_valid = 1'b0;
      end else if (w >= 0) begin
         m_ptr    = (w + 1) % N;
         mr_valid = 1'b1;
         mr_id    = w;
         mr_err   = blk;
         mr_rd    = !r_we[w];
         mr_data  = ref_mem[r_addr[w]];
         if (r_we[w] && !blk)
            for (int b = 0; b < BW; b++)
               if (r_be[w][b]) ref_mem[r_addr[w]][8*b +: 8] = r_wd[w][8*b +: 8];
      end else begin
         mr_valid = 1'b0;
      end
      last_win = w;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit            rs;
      logic [N-1:0]  req, we;
      bit            wpv;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      logic [N-1:0]  gnt;
      bit            mreq;
      logic [N-1:0]  rv;
      bit            err;
      bit            chk_rd;
      logic [DW-1:0] rd;
   } vec_t;

   function automatic vec_t v(bit rs, logic [N-1:0] req, logic [N-1:0] we, bit wpv,
                              logic [AW-1:0] a, logic [DW-1:0] wd, logic [N-1:0] gnt,
                              bit mreq, logic [N-1:0] rv, bit err, bit chk_rd,
                              logic [DW-1:0] rd);
      vec_t r;
      r.rs = rs; r.req = req; r.we = we; r.wpv = wpv; r.a = a; r.wd = wd;
      r.gnt = gnt; r.mreq = mreq; r.rv = rv; r.err = err; r.chk_rd = chk_rd; r.rd = rd;
      return r;
   endfunction

   initial begin
      vec_t          tbl [$];
      logic [DW-1:0] old;

      for (int i = 0; i < NW; i++) ref_mem[i] = pre(i);
      m_ptr = 0; mr_valid = 1'b0; mr_id = 0; mr_err = 1'b0; mr_rd = 1'b0; mr_data = '0;
      last_win = -1;
      rst = 1'b1; wp = 1'b0; r_req = '0; r_we = '0;
      for (int k = 0; k < N; k++) begin
         r_addr[k] = '0; r_wd[k] = '0; r_be[k] = '0;
      end
      repeat (2) adv();

      // Requests during reset are never granted.
      r_req = 3'b111;
      eval();
      chk("rst_gnt", 64'(bus_if.gnt_o), 64'(0));
      chk("rst_mem_req", 64'(mem_req), 64'(0));
      adv();
      rst = 1'b0; r_req = '0;
      eval();
      chk("rst_rvalid", 64'(bus_if.rvalid_o), 64'(0));
      chk("rst_err", 64'(bus_if.err_o), 64'(0));
      adv();

      //         rs req     we      wp addr     wdata     gnt     mrq rv      err crd rdata
      tbl.push_back(v(0, 3'b111, 3'b000, 0, 10'h010, 32'h0,    3'b001, 1, 3'b000, 0, 0, 32'h0));
      tbl.push_back(v(0, 3'b111, 3'b000, 0, 10'h010, 32'h0,    3'b010, 1, 3'b001, 0, 1, pre(10'h010)));
      tbl.push_back(v(0, 3'b111, 3'b000, 0, 10'h010, 32'h0,    3'b100, 1, 3'b010, 0, 1, pre(10'h010)));
      tbl.push_back(v(0, 3'b111, 3'b000, 0, 10'h010, 32'h0,    3'b001, 1, 3'b100, 0, 1, pre(10'h010)));
      tbl.push_back(v(0, 3'b111, 3'b000, 0, 10'h010, 32'h0,    3'b010, 1, 3'b001, 0, 1, pre(10'h010)));
      tbl.push_back(v(0, 3'b111, 3'b000, 0, 10'h010, 32'h0,    3'b100, 1, 3'b010, 0, 1, pre(10'h010)));
      tbl.push_back(v(0, 3'b000, 3'b000, 0, 10'h010, 32'h0,    3'b000, 0, 3'b100, 0, 1, pre(10'h010)));
      tbl.push_back(v(0, 3'b000, 3'b000, 0, 10'h010, 32'h0,    3'b000, 0, 3'b000, 0, 0, 32'h0));
      tbl.push_back(v(0, 3'b001, 3'b001, 1, 10'h030, 32'h1111, 3'b001, 0, 3'b000, 0, 0, 32'h0));
      tbl.push_back(v(0, 3'b010, 3'b000, 1, 10'h030, 32'h0,    3'b010, 1, 3'b001, 1, 0, 32'h0));
      tbl.push_back(v(0, 3'b100, 3'b100, 1, 10'h030, 32'h1111, 3'b100, 1, 3'b010, 0, 1, pre(10'h030)));
      tbl.push_back(v(0, 3'b001, 3'b000, 0, 10'h030, 32'h0,    3'b001, 1, 3'b100, 0, 0, 32'h0));
      tbl.push_back(v(0, 3'b000, 3'b000, 0, 10'h030, 32'h0,    3'b000, 0, 3'b001, 0, 1, 32'h1111));
      tbl.push_back(v(0, 3'b100, 3'b000, 0, 10'h040, 32'h0,    3'b100, 1, 3'b000, 0, 0, 32'h0));
      tbl.push_back(v(0, 3'b100, 3'b000, 0, 10'h040, 32'h0,    3'b100, 1, 3'b100, 0, 1, pre(10'h040)));
      tbl.push_back(v(0, 3'b101, 3'b000, 0, 10'h040, 32'h0,    3'b001, 1, 3'b100, 0, 1, pre(10'h040)));
      tbl.push_back(v(0, 3'b100, 3'b000, 0, 10'h040, 32'h0,    3'b100, 1, 3'b001, 0, 1, pre(10'h040)));
      tbl.push_back(v(0, 3'b000, 3'b000, 0, 10'h040, 32'h0,    3'b000, 0, 3'b100, 0, 1, pre(10'h040)));
      tbl.push_back(v(0, 3'b010, 3'b000, 0, 10'h010, 32'h0,    3'b010, 1, 3'b000, 0, 0, 32'h0));
      tbl.push_back(v(1, 3'b111, 3'b000, 0, 10'h010, 32'h0,    3'b000, 0, 3'b000, 0, 0, 32'h0));
      tbl.push_back(v(0, 3'b111, 3'b000, 0, 10'h010, 32'h0,    3'b001, 1, 3'b000, 0, 0, 32'h0));
      tbl.push_back(v(0, 3'b000, 3'b000, 0, 10'h010, 32'h0,    3'b000, 0, 3'b001, 0, 1, pre(10'h010)));

      for (int i = 0; i < tbl.size(); i++) begin
         rst = tbl[i].rs; wp = tbl[i].wpv; r_req = tbl[i].req; r_we = tbl[i].we;
         for (int k = 0; k < N; k++) begin
            r_addr[k] = tbl[i].a; r_wd[k] = tbl[i].wd; r_be[k] = 4'hF;
         end
         eval();
         chk($sformatf("v%0d_gnt", i), 64'(bus_if.gnt_o), 64'(tbl[i].gnt));
         chk($sformatf("v%0d_mem_req", i), 64'(mem_req), 64'(tbl[i].mreq));
         chk($sformatf("v%0d_rvalid", i), 64'(bus_if.rvalid_o), 64'(tbl[i].rv));
         chk($sformatf("v%0d_err", i), 64'(bus_if.err_o), 64'(tbl[i].err));
         if (tbl[i].chk_rd) chk($sformatf("v%0d_rdata", i), 64'(bus_if.rdata_o), 64'(tbl[i].rd));
         adv();
      end
      rst = 1'b0; wp = 1'b0; r_req = '0; r_we = '0;

      // Partial-byte write from req 1, then read-back in the following cycle.
      old = pre(10'h020);
      r_req[1] = 1'b1; r_we[1] = 1'b1; r_addr[1] = 10'h020; r_wd[1] = 32'hDEAD_BEEF; r_be[1] = 4'b0011;
      eval();
      chk("wr_gnt", 64'(bus_if.gnt_o), 64'(3'b010));
      chk("wr_mem_be", 64'(mem_be), 64'(4'b0011));
      adv();
      r_we[1] = 1'b0; r_be[1] = 4'hF;
      eval();
      chk("wr_rvalid", 64'(bus_if.rvalid_o), 64'(3'b010));
      chk("wr_err", 64'(bus_if.err_o), 64'(0));
      chk("rd_gnt", 64'(bus_if.gnt_o), 64'(3'b010));
      adv();
      r_req = '0;
      eval();
      chk("rd_rvalid", 64'(bus_if.rvalid_o), 64'(3'b010));
      chk("rd_err", 64'(bus_if.err_o), 64'(0));
      chk("rd_merge", 64'(bus_if.rdata_o), 64'({old[31:16], 16'hBEEF}));
      adv();

      // Req 1 loses to req 0 and withdraws: it must never see a grant or a response.
      r_req = 3'b011; r_we = '0; r_addr[0] = 10'h010; r_addr[1] = 10'h010;
      eval();
      chk("drop_gnt", 64'(bus_if.gnt_o), 64'(3'b001));
      adv();
      r_req = '0;
      eval();
      chk("drop_rvalid", 64'(bus_if.rvalid_o), 64'(3'b001));
      chk("drop_gnt1", 64'(bus_if.gnt_o[1]), 64'(0));
      adv();
      eval();
      chk("drop_rvalid_end", 64'(bus_if.rvalid_o), 64'(0));
      adv();

      // Random traffic; pending requests stay stable until granted.
      r_req = '0; r_we = '0; last_win = -1;
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         wp  = 1'($urandom_range(0, 1));
         for (int k = 0; k < N; k++) begin
            if (!r_req[k] || last_win == k) begin
               if ($urandom_range(0, 9) < 6) begin
                  r_req[k]  = 1'b1;
                  r_we[k]   = ($urandom_range(0, 2) == 0);
                  r_addr[k] = AW'($urandom_range(0, 15));
                  r_wd[k]   = $urandom;
                  r_be[k]   = BW'($urandom_range(0, 15));
               end else begin
                  r_req[k] = 1'b0;
                  r_we[k]  = 1'b0;
               end
            end else if ($urandom_range(0, 19) == 0) begin
               r_req[k] = 1'b0;
            end
         end
         eval();
         adv();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
